// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Behavioural memory model for an LC-3 style core. It has two independent
// ports that share one 2^AW x 16 word array:
//   instruction port : pc, instrmem_rd          -> Instr_dout, complete_instr
//   data port        : Data_addr, Data_din,
//                      Data_rd, Data_en         -> Data_dout, complete_data
// Each port runs its own IDLE/BUSY/RESP FSM. A request is sampled in IDLE.
// The completion pulse is registered and rises exactly LAT cycles after the
// sample edge. It stays high for the single RESP cycle.
// Data writes commit on the edge that ends RESP, so an instruction read
// completing in the same cycle still sees the old word.
// clock : rising-edge clock
// reset : synchronous, active-high; clears the FSMs and outputs, not the array
module lc3_mem_responder #(
    parameter int INSTR_LAT = 1,
    parameter int DATA_LAT  = 2,
    parameter int AW        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        Data_rd,
    input  logic        Data_en,
    output logic [15:0] Data_dout,
    output logic        complete_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] I_LOAD = 4'(INSTR_LAT - 1);
    localparam logic [3:0] D_LOAD = 4'(DATA_LAT - 1);

    logic [15:0]   mem [0:(1 << AW) - 1];

    state_t        i_state;
    logic [3:0]    i_cnt;
    logic [AW-1:0] i_addr;

    state_t        d_state;
    logic [3:0]    d_cnt;
    logic [AW-1:0] d_addr;
    logic          d_rd;
    logic [15:0]   d_din;

    // Upper address bits are intentionally dropped, so addresses wrap.
    generate
        if (AW < 16) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^{pc[15:AW], Data_addr[15:AW]};
        end
    endgenerate

    // Instruction port FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            i_state        <= IDLE;
            i_cnt          <= 4'd0;
            complete_instr <= 1'b0;
            Instr_dout     <= 16'h0000;
        end else begin
            complete_instr <= 1'b0;
            case (i_state)
                IDLE: begin
                    if (instrmem_rd) begin
                        i_addr  <= pc[AW-1:0];
                        i_cnt   <= I_LOAD;
                        i_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_cnt == 4'd0) begin
                        i_state        <= RESP;
                        complete_instr <= 1'b1;
                        Instr_dout     <= mem[i_addr];
                    end else begin
                        i_cnt <= i_cnt - 4'd1;
                    end
                end
                RESP:    i_state <= IDLE;
                default: i_state <= IDLE;
            endcase
        end
    end

    // Data port FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            d_state       <= IDLE;
            d_cnt         <= 4'd0;
            complete_data <= 1'b0;
            Data_dout     <= 16'h0000;
        end else begin
            complete_data <= 1'b0;
            case (d_state)
                IDLE: begin
                    if (Data_en) begin
                        d_addr  <= Data_addr[AW-1:0];
                        d_rd    <= Data_rd;
                        d_din   <= Data_din;
                        d_cnt   <= D_LOAD;
                        d_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (d_cnt == 4'd0) begin
                        d_state       <= RESP;
                        complete_data <= 1'b1;
                        // A write leaves Data_dout holding its last read value.
                        if (d_rd) begin
                            Data_dout <= mem[d_addr];
                        end
                    end else begin
                        d_cnt <= d_cnt - 4'd1;
                    end
                end
                RESP:    d_state <= IDLE;
                default: d_state <= IDLE;
            endcase
        end
    end

    // Write commit on the edge leaving RESP. A reset on that edge aborts it.
    // The array itself is never cleared.
    always_ff @(posedge clock) begin
        if (!reset && d_state == RESP && !d_rd) begin
            mem[d_addr] <= d_din;
        end
    end

endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 Parameter INSTR_LAT, default 1, cycles from instruction request sample to complete_instr; legal 1..15.
REQ-002 Parameter DATA_LAT, default 2, cycles from data request sample to complete_data; legal 1..15.
REQ-003 Parameter AW, default 8, word-address bits used; array depth 2^AW x 16.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc  input  16  instruction word address.
REQ-007 instrmem_rd  input  1  instruction read request.
REQ-008 Instr_dout  output  16  instruction word; valid while complete_instr=1.
REQ-009 complete_instr  output  1  one-cycle instruction completion pulse.
REQ-010 Data_addr  input  16  data word address.
REQ-011 Data_din  input  16  write data from CPU.
REQ-012 Data_rd  input  1  1=read, 0=write; qualified by Data_en.
REQ-013 Data_en  input  1  data request strobe, driven by system top from CPU memory state.
REQ-014 Data_dout  output  16  read data; valid while complete_data=1 for reads.
REQ-015 complete_data  output  1  one-cycle data completion pulse, reads and writes.

Function
REQ-016 Independent FSMs per port (instruction and data), states IDLE, BUSY, RESP.
REQ-017 IDLE: request sampled (instrmem_rd=1, or Data_en=1); capture address low AW bits, Data_rd, Data_din; load counter with LAT-1; go BUSY.
REQ-018 BUSY: counter decrements each cycle; at 0, go RESP. With LAT=1, BUSY lasts one cycle.
REQ-019 Completion pulse is high only in RESP, exactly LAT cycles after sample edge; RESP always returns to IDLE next cycle.
REQ-020 Requests accepted only in IDLE; request held in cycle after RESP is a new request, so back-to-back spacing = LAT+2 cycles.
REQ-021 Input changes (address, Data_rd, Data_din) during BUSY/RESP ignored; captured values used.
REQ-022 Reads: array read at captured address; registered so Instr_dout/Data_dout valid in RESP; outputs hold last value otherwise.
REQ-023 Writes: array updated with captured Data_din on rising edge ending RESP cycle; Data_dout unchanged by write.
REQ-024 Address bits [15:AW] ignored; addresses wrap modulo 2^AW.
REQ-025 Instruction read and data write same address same RESP cycle: instruction returns pre-write value.
REQ-026 Data read after write to same address returns written value if read RESP follows write commit edge.
REQ-027 Ports never stall each other; both may be in RESP same cycle.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 reset=1: both FSMs IDLE, counters 0, complete_instr=0, complete_data=0, Instr_dout=0, Data_dout=0.
REQ-030 Reset during BUSY or RESP aborts access; pending write not committed.
REQ-031 Array contents not cleared by reset; preserved across reset.
REQ-032 Request present in reset cycle ignored; first sample on first edge with reset=0.

Verification
REQ-033 DATA_LAT=2: write 0x1234 to 0x0010 (Data_en=1, Data_rd=0), then read 0x0010 -> complete_data 2 cycles after each sample; read Data_dout=0x1234.
REQ-034 INSTR_LAT=1, instrmem_rd held high, pc=0x0000 then 0x0001 -> complete_instr pulses every 3 cycles; Instr_dout matches preloaded words.
REQ-035 AW=8: write 0xBEEF to 0x0105, read 0x0005 -> Data_dout=0xBEEF (wrap).
REQ-036 Data write 0xAAAA to 0x0020, change Data_din to 0x5555 during BUSY -> stored value 0xAAAA.
REQ-037 Write 0x7777 to 0x0030 (previously 0x1111), reset asserted in BUSY -> outputs 0, no pulse, later read returns 0x1111.
REQ-038 Instruction read and data write of 0x0040 completing same cycle -> Instr_dout = old value, next read returns new value.
